// File: rtl/gelato_warp_scheduler.sv
// rtl/gelato_warp_scheduler.sv - round-robin warp scheduler with per-warp in-flight credits and one issue register.
// Optional greedy-then-round-robin selection is enabled by defining GELATO_WARPSKD_GTO_EN.
module gelato_warp_scheduler #(
   parameter int WARP_NUM     = 4,
   parameter int INST_W       = 64,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 rdy,
   input  logic [WARP_NUM-1:0]                  buf_valid,
   input  logic [WARP_NUM-1:0][INST_W-1:0]      buf_inst,
   output logic [WARP_NUM-1:0]                  buf_caught,
   output logic                                 issue_valid,
   input  logic                                 issue_ready,
   output logic [INST_W-1:0]                    issue_inst,
   output logic [$clog2(WARP_NUM)-1:0]          issue_warp,
   input  logic                                 commit_valid,
   input  logic [$clog2(WARP_NUM)-1:0]          commit_warp
);

   localparam int WID = $clog2(WARP_NUM);
   localparam int CW  = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

   logic [WID-1:0]                rr_ptr;
   logic [WID-1:0]                last_warp;
   logic [WID-1:0]                search_start;
   logic [WID-1:0]                cand;
   logic [WID-1:0]                sel;
   logic                          sel_found;
   logic                          slot_free;
   logic                          do_sel;
   logic [WARP_NUM-1:0]           eligible;
   logic [WARP_NUM-1:0]           inc_v;
   logic [WARP_NUM-1:0]           dec_v;
   logic [WARP_NUM-1:0][CW-1:0]   inflight;

   function automatic logic [WID-1:0] next_warp(input logic [WID-1:0] w);
      if (int'(w) == WARP_NUM - 1) return '0;
      else return w + 1'b1;
   endfunction

   assign slot_free = !issue_valid || issue_ready;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < WARP_NUM; i++)
         eligible[i] = buf_valid[i] && (inflight[i] < MAX_CNT);
   end

`ifdef GELATO_WARPSKD_GTO_EN
   assign search_start = next_warp(last_warp);
`else
   assign search_start = rr_ptr;
`endif

   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      cand      = search_start;
      for (int k = 0; k < WARP_NUM; k++) begin
         if (!sel_found && eligible[cand]) begin
            sel       = cand;
            sel_found = 1'b1;
         end
         cand = next_warp(cand);
      end
`ifdef GELATO_WARPSKD_GTO_EN
      // Stay on the last issued warp as long as it can keep issuing.
      if (eligible[last_warp]) begin
         sel       = last_warp;
         sel_found = 1'b1;
      end
`endif
   end

   // Gating with rst_n keeps the pop strobe quiet while the scheduler is held in reset.
   assign do_sel = rst_n && rdy && slot_free && sel_found;

   always_comb begin
      buf_caught = '0;
      if (do_sel) buf_caught[sel] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_valid <= 1'b0;
         issue_inst  <= '0;
         issue_warp  <= '0;
         rr_ptr      <= '0;
         last_warp   <= '0;
      end else if (do_sel) begin
         issue_valid <= 1'b1;
         issue_inst  <= buf_inst[sel];
         issue_warp  <= sel;
         rr_ptr      <= next_warp(sel);
         last_warp   <= sel;
      end else if (issue_valid && issue_ready) begin
         issue_valid <= 1'b0;
      end
   end

   always_comb begin
      inc_v = '0;
      dec_v = '0;
      for (int i = 0; i < WARP_NUM; i++) begin
         inc_v[i] = do_sel && (sel == WID'(i));
         dec_v[i] = commit_valid && (commit_warp == WID'(i));
      end
   end

   // A simultaneous issue and commit on one warp cancel; a stray commit never underflows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
      end else begin
         for (int i = 0; i < WARP_NUM; i++) begin
            if (inc_v[i] && !dec_v[i])
               inflight[i] <= inflight[i] + 1'b1;
            else if (dec_v[i] && !inc_v[i] && inflight[i] != '0)
               inflight[i] <= inflight[i] - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// tb/tb_gelato_warp_scheduler.sv - scoreboard bench for gelato_warp_scheduler.
module tb_gelato_warp_scheduler;

   logic              clk;
   logic              rst_n;
   logic              rdy;
   logic [3:0]        buf_valid;
   logic [3:0][63:0]  buf_inst;
   logic [3:0]        buf_caught;
   logic              issue_valid;
   logic              issue_ready;
   logic [63:0]       issue_inst;
   logic [1:0]        issue_warp;
   logic              commit_valid;
   logic [1:0]        commit_warp;

   typedef struct {
      logic [1:0]  warp;
      logic [63:0] inst;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] seq[4];
   logic [31:0] exp_cnt[4];
   logic [63:0] last_exp_inst;
   int          checks = 0;
   int          errors = 0;

   gelato_warp_scheduler #(.WARP_NUM(4), .INST_W(64), .MAX_INFLIGHT(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rdy          (rdy),
      .buf_valid    (buf_valid),
      .buf_inst     (buf_inst),
      .buf_caught   (buf_caught),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_inst   (issue_inst),
      .issue_warp   (issue_warp),
      .commit_valid (commit_valid),
      .commit_warp  (commit_warp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer model: each head word carries its warp id and pop count.
   initial for (int i = 0; i < 4; i++) begin
      seq[i]     = 32'd0;
      exp_cnt[i] = 32'd0;
   end

   always @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (buf_caught[i]) seq[i] <= seq[i] + 32'd1;

   always_comb begin
      buf_inst = '0;
      for (int i = 0; i < 4; i++) buf_inst[i] = {32'(i), seq[i]};
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int w);
      exp_t e;
      e.warp = 2'(w);
      e.inst = {32'(w), exp_cnt[w]};
      exp_cnt[w] = exp_cnt[w] + 32'd1;
      last_exp_inst = e.inst;
      exp_q.push_back(e);
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      int r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   // One cycle: compare the pop strobe mid-cycle, record the expected issue, advance.
   task automatic step(input logic [3:0] exp_caught, input string name);
      @(negedge clk);
      check(name, 64'(buf_caught), 64'(exp_caught));
      if (exp_caught != 4'b0000) push(onehot_idx(exp_caught));
      @(posedge clk); #1;
   endtask

   task automatic drain();
      buf_valid   = 4'b0000;
      issue_ready = 1'b1;
      for (int w = 0; w < 4; w++) begin
         commit_valid = 1'b1;
         commit_warp  = 2'(w);
         repeat (2) begin @(posedge clk); #1; end
      end
      commit_valid = 1'b0;
      commit_warp  = 2'd0;
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && issue_valid && issue_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue warp=%0d inst=%0h expected=none at %0t", issue_warp, issue_inst, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("issue_warp", 64'(issue_warp), 64'(e.warp));
            check("issue_inst", issue_inst, e.inst);
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      rdy          = 1'b1;
      buf_valid    = 4'b1111;
      issue_ready  = 1'b1;
      commit_valid = 1'b0;
      commit_warp  = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_caught", 64'(buf_caught), 64'd0);
      check("reset_valid", 64'(issue_valid), 64'd0);
      check("reset_inst", issue_inst, 64'd0);
      check("reset_warp", 64'(issue_warp), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 1: round-robin sweep over all four warps
      step(4'b0001, "t1_caught0");
      step(4'b0010, "t1_caught1");
      step(4'b0100, "t1_caught2");
      step(4'b1000, "t1_caught3");
      drain();

      // 2: credit limit on a single warp
      buf_valid = 4'b0100;
      step(4'b0100, "t2_first");
      step(4'b0100, "t2_second");
      step(4'b0000, "t2_blocked");
      @(negedge clk);
      check("t2_valid_drop", 64'(issue_valid), 64'd0);
      check("t2_caught_idle", 64'(buf_caught), 64'd0);
      @(posedge clk); #1;
      commit_valid = 1'b1;
      commit_warp  = 2'd2;
      step(4'b0000, "t2_commit_cycle");
      commit_valid = 1'b0;
      step(4'b0100, "t2_credit_back");
      step(4'b0000, "t2_blocked_again");
      drain();

      // 3: backpressure holds the issue register
      buf_valid   = 4'b0011;
      issue_ready = 1'b0;
      step(4'b0001, "t3_first");
      repeat (5) begin
         @(negedge clk);
         check("t3_hold_caught", 64'(buf_caught), 64'd0);
         check("t3_hold_valid", 64'(issue_valid), 64'd1);
         check("t3_hold_inst", issue_inst, last_exp_inst);
         @(posedge clk); #1;
      end
      issue_ready = 1'b1;
      step(4'b0010, "t3_release_sel");
      buf_valid = 4'b0000;
      @(negedge clk);
      check("t3_valid_stays", 64'(issue_valid), 64'd1);
      @(posedge clk); #1;
      drain();

      // 4: issue and commit on one warp in the same cycle; commit at zero credit
      buf_valid = 4'b0010;
      step(4'b0010, "t4_first");
      commit_valid = 1'b1;
      commit_warp  = 2'd1;
      step(4'b0010, "t4_sel_and_commit");
      commit_valid = 1'b0;
      step(4'b0010, "t4_third");
      step(4'b0000, "t4_full");
      commit_valid = 1'b1;
      commit_warp  = 2'd3;
      step(4'b0000, "t4_stray_commit");
      commit_valid = 1'b0;
      buf_valid    = 4'b1000;
      step(4'b1000, "t4_w3_first");
      step(4'b1000, "t4_w3_second");
      step(4'b0000, "t4_w3_full");
      drain();

      // 5: rdy low freezes selection but not handshake or commits
      buf_valid   = 4'b0001;
      issue_ready = 1'b0;
      step(4'b0001, "t5_pending");
      rdy       = 1'b0;
      buf_valid = 4'b1111;
      @(negedge clk);
      check("t5_rdy0_caught_a", 64'(buf_caught), 64'd0);
      check("t5_rdy0_hold", 64'(issue_valid), 64'd1);
      @(posedge clk); #1;
      issue_ready  = 1'b1;
      commit_valid = 1'b1;
      commit_warp  = 2'd0;
      step(4'b0000, "t5_rdy0_caught_b");
      commit_valid = 1'b0;
      @(negedge clk);
      check("t5_rdy0_caught_c", 64'(buf_caught), 64'd0);
      check("t5_rdy0_drained", 64'(issue_valid), 64'd0);
      @(posedge clk); #1;
      rdy = 1'b1;
      step(4'b0010, "t5_rr_kept");
      buf_valid = 4'b0001;
      step(4'b0001, "t5_w0_first");
      step(4'b0001, "t5_w0_second");
      step(4'b0000, "t5_w0_full");
      drain();

      // 6: greedy or round-robin pattern with steady commits, then mid-stream reset
      buf_valid    = 4'b0011;
      commit_valid = 1'b1;
      commit_warp  = 2'd0;
`ifdef GELATO_WARPSKD_GTO_EN
      step(4'b0001, "t6_greedy_a");
      step(4'b0001, "t6_greedy_b");
      step(4'b0001, "t6_greedy_c");
      step(4'b0001, "t6_greedy_d");
      buf_valid = 4'b0010;
      step(4'b0010, "t6_switch");
`else
      step(4'b0010, "t6_rr_a");
      step(4'b0001, "t6_rr_b");
      step(4'b0010, "t6_rr_c");
      step(4'b0001, "t6_rr_d");
      buf_valid = 4'b0010;
      step(4'b0000, "t6_w1_full");
`endif
      commit_valid = 1'b0;
      buf_valid    = 4'b0000;
      step(4'b0000, "t6_flush");
      buf_valid   = 4'b0001;
      issue_ready = 1'b0;
      step(4'b0001, "t6_pending");
      step(4'b0000, "t6_stalled");
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(issue_valid), 64'd0);
      check("t6_rst_caught", 64'(buf_caught), 64'd0);
      check("t6_rst_warp", 64'(issue_warp), 64'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n       = 1'b1;
      issue_ready = 1'b1;
      buf_valid   = 4'b0010;
      step(4'b0010, "t6_credit_a");
      step(4'b0010, "t6_credit_b");
      step(4'b0000, "t6_credit_full");
      buf_valid = 4'b0000;
      repeat (3) begin @(posedge clk); #1; end
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
